// File: rtl/bpu_pred_pkg.sv
// Shared opcode constants, instruction classes and counter helper for the branch predictor.
package bpu_pred_pkg;

  localparam int unsigned MYRISCV_XLEN = 32;

  localparam logic [6:0] MYRISCV_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] MYRISCV_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] MYRISCV_OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    INS_NONE,
    INS_JAL,
    INS_JALR,
    INS_BXX
  } ins_class_e;

  function automatic ins_class_e decode_class(input logic [6:0] opc);
    case (opc)
      MYRISCV_OPC_JAL:    return INS_JAL;
      MYRISCV_OPC_JALR:   return INS_JALR;
      MYRISCV_OPC_BRANCH: return INS_BXX;
      default:            return INS_NONE;
    endcase
  endfunction

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_bht.sv
// Bimodal table of 2-bit saturating counters: combinational read, registered update.
module bpu_bht
  import bpu_pred_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [DEPTH-1:0][1:0] cnt_q;

  // Read returns the pre-update value on a same-index collision.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {DEPTH{CNT_INIT}};
    end else if (upd_valid_i) begin
      cnt_q[upd_idx_i] <= sat_cnt(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/bpu_pred.sv
// Fetch-to-decode branch prediction stage: pre-decode, target add, direction, output register.
module bpu_pred
  import bpu_pred_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned MODE      = 1,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         if_valid,
  output logic                         if_ready,
  input  logic [31:0]                  if_ins,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic                         flush,
  output logic                         bp_valid,
  input  logic                         bp_ready,
  output logic [ADDR_W-1:0]            bp_pc,
  output logic [31:0]                  bp_ins,
  output logic                         bp_taken,
  output logic [ADDR_W-1:0]            bp_target,
  output logic                         bp_jal,
  output logic                         bp_jalr,
  output logic                         bp_bxx,
  output logic [$clog2(BHT_DEPTH)-1:0] bp_idx,
  input  logic                         upd_valid,
  input  logic [$clog2(BHT_DEPTH)-1:0] upd_idx,
  input  logic                         upd_taken
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  ins_class_e        cls;
  logic [31:0]       imm_j, imm_b, imm;
  logic [ADDR_W-1:0] pc_imm, pc_p4, target;
  logic              taken;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        cnt_rd;
  logic              accept;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d;
  logic [31:0]       ins_q, ins_d;
  logic              taken_q, taken_d, jal_q, jal_d, jalr_q, jalr_d, bxx_q, bxx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  assign cls    = decode_class(if_ins[6:0]);
  assign imm_j  = {{12{if_ins[31]}}, if_ins[19:12], if_ins[20], if_ins[30:21], 1'b0};
  assign imm_b  = {{20{if_ins[31]}}, if_ins[7], if_ins[30:25], if_ins[11:8], 1'b0};
  assign imm    = (cls == INS_JAL) ? imm_j : imm_b;
  assign pc_imm = if_pc + imm[ADDR_W-1:0];
  assign pc_p4  = if_pc + ADDR_W'(4);
  assign rd_idx = if_pc[IDX_W+1:2];

  generate
    if (MODE == 1) begin : g_bht
      bpu_bht #(
        .DEPTH   (BHT_DEPTH),
        .IDX_W   (IDX_W),
        .CNT_INIT(CNT_INIT)
      ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (rd_idx),
        .rd_cnt_o   (cnt_rd),
        .upd_valid_i(upd_valid),
        .upd_idx_i  (upd_idx),
        .upd_taken_i(upd_taken)
      );
    end else begin : g_static
      logic unused_upd;
      assign unused_upd = ^{upd_valid, upd_idx, upd_taken};
      assign cnt_rd     = CNT_INIT;
    end
  endgenerate

  always_comb begin
    taken = 1'b0;
    case (cls)
      INS_JAL: taken = 1'b1;
      INS_BXX: taken = (MODE == 0) ? imm[31] : cnt_rd[1];
      default: taken = 1'b0;
    endcase
    target = taken ? pc_imm : pc_p4;
  end

  assign if_ready = !valid_q || bp_ready;
  assign accept   = if_valid && if_ready && !flush;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    taken_d  = taken_q;
    target_d = target_q;
    jal_d    = jal_q;
    jalr_d   = jalr_q;
    bxx_d    = bxx_q;
    idx_d    = idx_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      pc_d     = if_pc;
      ins_d    = if_ins;
      taken_d  = taken;
      target_d = target;
      jal_d    = (cls == INS_JAL);
      jalr_d   = (cls == INS_JALR);
      bxx_d    = (cls == INS_BXX);
      idx_d    = rd_idx;
    end else if (bp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      ins_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      jal_q    <= 1'b0;
      jalr_q   <= 1'b0;
      bxx_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      jal_q    <= jal_d;
      jalr_q   <= jalr_d;
      bxx_q    <= bxx_d;
      idx_q    <= idx_d;
    end
  end

  assign bp_valid  = valid_q;
  assign bp_pc     = pc_q;
  assign bp_ins    = ins_q;
  assign bp_taken  = taken_q;
  assign bp_target = target_q;
  assign bp_jal    = jal_q;
  assign bp_jalr   = jalr_q;
  assign bp_bxx    = bxx_q;
  assign bp_idx    = idx_q;

endmodule

// File: tb/tb_bpu_pred.sv
// Scoreboard bench for bpu_pred: a bimodal and a static instance share one stimulus stream.
module tb_bpu_pred;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_ins = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        bp_ready = 1'b0;
  logic        upd_valid = 1'b0;
  logic [5:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;

  logic        if_ready, bp_valid, bp_taken, bp_jal, bp_jalr, bp_bxx;
  logic [31:0] bp_pc, bp_ins, bp_target;
  logic [5:0]  bp_idx;

  logic        if_ready0, bp_valid0, bp_taken0, bp_jal0, bp_jalr0, bp_bxx0;
  logic [31:0] bp_pc0, bp_ins0, bp_target0;
  logic [5:0]  bp_idx0;

  bpu_pred #(.ADDR_W(32), .BHT_DEPTH(64), .MODE(1), .CNT_INIT(2'b01)) u_dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_ins(if_ins),
    .if_pc(if_pc), .flush(flush), .bp_valid(bp_valid), .bp_ready(bp_ready), .bp_pc(bp_pc),
    .bp_ins(bp_ins), .bp_taken(bp_taken), .bp_target(bp_target), .bp_jal(bp_jal),
    .bp_jalr(bp_jalr), .bp_bxx(bp_bxx), .bp_idx(bp_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken));

  bpu_pred #(.ADDR_W(32), .BHT_DEPTH(64), .MODE(0), .CNT_INIT(2'b01)) u_dut0 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready0), .if_ins(if_ins),
    .if_pc(if_pc), .flush(flush), .bp_valid(bp_valid0), .bp_ready(bp_ready), .bp_pc(bp_pc0),
    .bp_ins(bp_ins0), .bp_taken(bp_taken0), .bp_target(bp_target0), .bp_jal(bp_jal0),
    .bp_jalr(bp_jalr0), .bp_bxx(bp_bxx0), .bp_idx(bp_idx0), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        t1;
    logic [31:0] tg1;
    logic        t0;
    logic [31:0] tg0;
    logic [2:0]  cls;
    logic [5:0]  idx;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JALR = 32'h0000_80E7;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Monitor: every transfer to the decoder pops one expected prediction.
  always @(negedge clk) begin
    if (!rst && bp_valid && bp_ready && !flush) begin
      if (sb.size() == 0) begin
        check("unexpected_transfer", {32'd0, bp_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pc", {32'd0, bp_pc}, {32'd0, e.pc});
        check("ins", {32'd0, bp_ins}, {32'd0, e.ins});
        check("class", {61'd0, bp_jal, bp_jalr, bp_bxx}, {61'd0, e.cls});
        check("taken", {63'd0, bp_taken}, {63'd0, e.t1});
        check("target", {32'd0, bp_target}, {32'd0, e.tg1});
        check("idx", {58'd0, bp_idx}, {58'd0, e.idx});
        check("m0_valid", {63'd0, bp_valid0}, 64'd1);
        check("m0_taken", {63'd0, bp_taken0}, {63'd0, e.t0});
        check("m0_target", {32'd0, bp_target0}, {32'd0, e.tg0});
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] ins, input logic t1,
                      input logic [31:0] tg1, input logic t0, input logic [31:0] tg0,
                      input logic [2:0] cls);
    exp_t e;
    logic [31:0] p;
    bit acc;
    int unsigned n;
    p = pc;
    e.pc = pc; e.ins = ins; e.t1 = t1; e.tg1 = tg1; e.t0 = t0; e.tg0 = tg0;
    e.cls = cls; e.idx = p[7:2];
    acc = 1'b0;
    n = 0;
    if_valid = 1'b1; if_pc = pc; if_ins = ins;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = if_ready && !flush;
      @(posedge clk); #1;
      n++;
    end
    if (acc) sb.push_back(e);
    else check("accept_timeout", {32'd0, pc}, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic idle();
    if_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic train(input logic [5:0] idx, input logic t);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = t;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {63'd0, bp_valid}, 64'd0);
    check({tag, "_data"}, {bp_pc, bp_ins}, 64'd0);
    check({tag, "_tgt"}, {25'd0, bp_target, bp_taken, bp_jal, bp_jalr, bp_bxx, bp_idx}, 64'd0);
    check({tag, "_m0"}, {bp_valid0, bp_pc0[30:0], bp_target0}, 64'd0);
  endtask

  initial begin
    int unsigned n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_cleared("reset");
    check("reset_if_ready", {63'd0, if_ready}, 64'd1);
    bp_ready = 1'b1;

    send(32'h0000_0100, enc_b(13'd8),      1'b0, 32'h0000_0104, 1'b0, 32'h0000_0104, 3'b001);
    send(32'h8000_0000, enc_j(21'h10),     1'b1, 32'h8000_0010, 1'b1, 32'h8000_0010, 3'b100);
    send(32'hFFFF_FFF0, enc_j(21'h20),     1'b1, 32'h0000_0010, 1'b1, 32'h0000_0010, 3'b100);
    send(32'h0000_0200, enc_b(13'h1FF8),   1'b0, 32'h0000_0204, 1'b1, 32'h0000_01F8, 3'b001);
    send(32'h0000_0200, enc_b(13'd8),      1'b0, 32'h0000_0204, 1'b0, 32'h0000_0204, 3'b001);
    send(32'h0000_0300, JALR,              1'b0, 32'h0000_0304, 1'b0, 32'h0000_0304, 3'b010);
    send(32'h0000_0304, NOP,               1'b0, 32'h0000_0308, 1'b0, 32'h0000_0308, 3'b000);
    idle();

    // idx 5 counter: 01 -> 10 -> 11
    train(6'd5, 1'b1);
    train(6'd5, 1'b1);
    send(32'h0000_0014, enc_b(13'd8), 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0018, 3'b001);
    idle();
    train(6'd5, 1'b1);
    send(32'h0000_0014, enc_b(13'd8), 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0018, 3'b001);
    idle();
    // 3 -> 2 -> 1 -> 0, hold at 0, then up to 1
    repeat (4) train(6'd5, 1'b0);
    train(6'd5, 1'b1);
    send(32'h0000_0014, enc_b(13'd8), 1'b0, 32'h0000_0018, 1'b0, 32'h0000_0018, 3'b001);
    // same-cycle update (1 -> 2) and read: old value seen, new one next cycle
    upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b1;
    send(32'h0000_0014, enc_b(13'd8), 1'b0, 32'h0000_0018, 1'b0, 32'h0000_0018, 3'b001);
    upd_valid = 1'b0;
    send(32'h0000_0014, enc_b(13'd8), 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0018, 3'b001);
    idle();

    bp_ready = 1'b0;
    send(32'h0000_0400, NOP, 1'b0, 32'h0000_0404, 1'b0, 32'h0000_0404, 3'b000);
    fork
      send(32'h0000_0404, NOP, 1'b0, 32'h0000_0408, 1'b0, 32'h0000_0408, 3'b000);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_if_ready", {63'd0, if_ready}, 64'd0);
          check("stall_hold", {31'd0, bp_valid, bp_pc}, {31'd0, 1'b1, 32'h0000_0400});
        end
        @(posedge clk); #1;
        bp_ready = 1'b1;
      end
    join
    send(32'h0000_0408, enc_j(21'h10),   1'b1, 32'h0000_0418, 1'b1, 32'h0000_0418, 3'b100);
    send(32'h0000_040C, enc_b(13'h1FF8), 1'b0, 32'h0000_0410, 1'b1, 32'h0000_0404, 3'b001);
    idle();

    bp_ready = 1'b0;
    send(32'h0000_0500, NOP, 1'b0, 32'h0000_0504, 1'b0, 32'h0000_0504, 3'b000);
    flush = 1'b1; bp_ready = 1'b1;
    if_valid = 1'b1; if_pc = 32'h0000_0600; if_ins = NOP;
    upd_valid = 1'b1; upd_idx = 6'd5; upd_taken = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; upd_valid = 1'b0;
    void'(sb.pop_front());
    check("flush_valid", {62'd0, bp_valid, bp_valid0}, 64'd0);
    // counter 2 -> 1 from the flush-cycle update
    send(32'h0000_0014, enc_b(13'd8), 1'b0, 32'h0000_0018, 1'b0, 32'h0000_0018, 3'b001);
    idle();
    train(6'd5, 1'b1);
    train(6'd5, 1'b1);

    bp_ready = 1'b0;
    send(32'h0000_0014, enc_b(13'd8), 1'b1, 32'h0000_001C, 1'b0, 32'h0000_0018, 3'b001);
    if_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_cleared("midreset");
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    bp_ready = 1'b1;
    send(32'h0000_0014, enc_b(13'd8), 1'b0, 32'h0000_0018, 1'b0, 32'h0000_0018, 3'b001);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
